// File: rtl/risc_sequencer_pkg.sv
// rtl/risc_sequencer_pkg.sv - shared opcodes, state encoding and width defaults for the sequencer
package risc_pkg;

   localparam int AW_DEF = 5;
   localparam int DW_DEF = 8;

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   typedef enum logic [2:0] {
      S0_FETCH_ADDR = 3'd0,
      S1_FETCH_RD   = 3'd1,
      S2_FETCH_LD   = 3'd2,
      S3_DECODE     = 3'd3,
      S4_OP_ADDR    = 3'd4,
      S5_OP_RD      = 3'd5,
      S6_EXEC       = 3'd6,
      S_HALT        = 3'd7
   } state_t;

   // Opcodes whose operand phase reads a data byte from memory
   function automatic logic op_reads(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/risc_sequencer_if.sv
// rtl/risc_sequencer_if.sv - memory bus between the sequencer (master) and the 32x8 memory (slave)
interface risc_sequencer_if #(
   parameter int AW = 5,
   parameter int DW = 8
);
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;

   modport master (
      output mem_addr, mem_rd, mem_wr, mem_data_in,
      input  mem_data_out
   );

   modport slave (
      input  mem_addr, mem_rd, mem_wr, mem_data_in,
      output mem_data_out
   );
endinterface

// File: rtl/risc_sequencer_alu.sv
// rtl/risc_sequencer_alu.sv - combinational accumulator update and zero flag
module risc_alu
   import risc_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [2:0]    i_opcode,
   input  logic [DW-1:0] i_acc,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_next_acc,
   output logic          o_zero
);

   // Non-arithmetic opcodes pass the accumulator through unchanged
   always_comb begin
      o_next_acc = i_acc;
      case (i_opcode)
         OP_ADD:  o_next_acc = i_acc + i_data;
         OP_AND:  o_next_acc = i_acc & i_data;
         OP_XOR:  o_next_acc = i_acc ^ i_data;
         OP_LDA:  o_next_acc = i_data;
         default: o_next_acc = i_acc;
      endcase
   end

   assign o_zero = (i_acc == '0);

endmodule

// File: rtl/risc_sequencer.sv
// rtl/risc_sequencer.sv - 7-phase fetch/execute sequencer; optional retire counter under RISC_SEQ_RETIRE_CNT_EN
module risc_sequencer
   import risc_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   risc_sequencer_if.master     mem,
   output logic                 halt,
   output logic [AW-1:0]        pc,
`ifdef RISC_SEQ_RETIRE_CNT_EN
   output logic [DW-1:0]        acc,
   output logic [15:0]          retired
`else
   output logic [DW-1:0]        acc
`endif
);

   state_t        r_state;
   state_t        w_next_state;
   logic [AW-1:0] r_pc;
   logic [DW-1:0] r_ir;
   logic [DW-1:0] r_acc;
   logic [2:0]    w_opcode;
   logic [AW-1:0] w_operand;
   logic [DW-1:0] w_next_acc;
   logic          w_zero;

   assign w_opcode  = r_ir[DW-1:AW];
   assign w_operand = r_ir[AW-1:0];

   risc_alu #(.DW(DW)) u_alu (
      .i_opcode   (w_opcode),
      .i_acc      (r_acc),
      .i_data     (mem.mem_data_out),
      .o_next_acc (w_next_acc),
      .o_zero     (w_zero)
   );

   // State register; reset lands in FETCH_ADDR so the first cycle after release fetches pc=0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S0_FETCH_ADDR;
      else        r_state <= w_next_state;
   end

   // Phase sequencing; HLT leaves the loop after decode and parks until reset
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S0_FETCH_ADDR: w_next_state = S1_FETCH_RD;
         S1_FETCH_RD:   w_next_state = S2_FETCH_LD;
         S2_FETCH_LD:   w_next_state = S3_DECODE;
         S3_DECODE:     w_next_state = (w_opcode == OP_HLT) ? S_HALT : S4_OP_ADDR;
         S4_OP_ADDR:    w_next_state = S5_OP_RD;
         S5_OP_RD:      w_next_state = S6_EXEC;
         S6_EXEC:       w_next_state = S0_FETCH_ADDR;
         default:       w_next_state = S_HALT;
      endcase
   end

   // Moore bus outputs decoded from state and ir only
   always_comb begin
      mem.mem_addr = r_pc;
      mem.mem_rd   = 1'b0;
      mem.mem_wr   = 1'b0;
      halt         = 1'b0;
      case (r_state)
         S1_FETCH_RD, S2_FETCH_LD: mem.mem_rd = 1'b1;
         S4_OP_ADDR:               mem.mem_addr = w_operand;
         S5_OP_RD: begin
            mem.mem_addr = w_operand;
            mem.mem_rd   = op_reads(w_opcode);
         end
         S6_EXEC: begin
            mem.mem_addr = w_operand;
            mem.mem_rd   = op_reads(w_opcode);
            mem.mem_wr   = (w_opcode == OP_STO);
         end
         S_HALT:                   halt = 1'b1;
         default:                  mem.mem_addr = r_pc;
      endcase
   end

   assign mem.mem_data_in = r_acc;
   assign pc              = r_pc;
   assign acc             = r_acc;

   // Datapath: ir loads in FETCH_LD, pc steps in DECODE, acc/pc resolve in EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc  <= '0;
         r_ir  <= '0;
         r_acc <= '0;
      end else begin
         case (r_state)
            S2_FETCH_LD: r_ir <= mem.mem_data_out;
            S3_DECODE:   r_pc <= r_pc + 1'b1;
            S6_EXEC: begin
               r_acc <= w_next_acc;
               if (w_opcode == OP_JMP)
                  r_pc <= w_operand;
               else if ((w_opcode == OP_SKZ) && w_zero)
                  r_pc <= r_pc + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef RISC_SEQ_RETIRE_CNT_EN
   // Counts completed EXEC phases, holding at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired <= '0;
      else if ((r_state == S6_EXEC) && (retired != 16'hFFFF))
         retired <= retired + 16'd1;
   end
`endif

endmodule
